// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES       = 4;
  localparam int unsigned FQ_DEFAULT_DEPTH = 4;

  // Clears the byte-offset bits of a fetch address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: IM request/response, ALU redirect and decode handshake.
// master = fetch_queue side, slave = memory/pipeline side.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = fetch_pkg::FQ_DEFAULT_DEPTH
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          im_req;
  logic [31:0]   im_addr;
  logic [31:0]   im_rdata;
  logic          branch_true;
  logic [31:0]   new_addr;
  logic          id_valid;
  logic [31:0]   id_inst;
  logic [31:0]   id_pc;
  logic          id_ready;
  logic [CW-1:0] fq_count;

  modport master (
    output im_req, im_addr, id_valid, id_inst, id_pc, fq_count,
    input  im_rdata, branch_true, new_addr, id_ready
  );

  modport slave (
    input  im_req, im_addr, id_valid, id_inst, id_pc, fq_count,
    output im_rdata, branch_true, new_addr, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Entry storage for the fetch queue: circular buffer with count, clear,
// and simultaneous push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !clear;
  assign rd_en = pop && !empty && !clear;
  assign rdata = mem[rd_ptr];

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; clear wins over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IM and the IF/ID register.
// Optional feature: define FETCHQ_BYPASS_EN to let a response arriving into
// an empty queue reach decode in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          im_req_w;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  resp;

  // Credit: queued entries plus the outstanding response never exceed DEPTH.
  assign im_req_w    = !rst && ((32'(count) + 32'(inflight)) < DEPTH);
  assign fq.im_req   = im_req_w;
  assign fq.im_addr  = fpc;
  assign fq.fq_count = count;
  assign resp.pc     = req_pc;
  assign resp.inst   = fq.im_rdata;

  // Fetch PC, outstanding-request flag and the PC of that request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (fq.branch_true) begin
      fpc      <= word_align(fq.new_addr);
      inflight <= 1'b0;
    end else begin
      inflight <= im_req_w;
      if (im_req_w) begin
        fpc    <= fpc + 32'(INST_BYTES);
        req_pc <= fpc;
      end
    end
  end

  // Decode-side outputs and queue push/pop steering.
  always_comb begin
    fq.id_valid = !empty;
    fq.id_inst  = empty ? '0 : head.inst;
    fq.id_pc    = empty ? '0 : head.pc;
    pop         = !empty && fq.id_ready && !fq.branch_true;
`ifdef FETCHQ_BYPASS_EN
    push        = inflight && !fq.branch_true && !(empty && fq.id_ready);
    if (empty && inflight && !fq.branch_true) begin
      fq.id_valid = 1'b1;
      fq.id_inst  = fq.im_rdata;
      fq.id_pc    = req_pc;
    end
`else
    push        = inflight && !fq.branch_true;
`endif
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fq.branch_true),
    .push  (push),
    .pop   (pop),
    .wdata (resp),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  no_overflow: assert property (@(posedge clk) disable iff (rst) (push && full) |-> pop);
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build, no bypass).
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  always #5 clk = ~clk;

  fetch_entry_t m_q[$];
  logic [31:0]  m_fpc;
  logic [31:0]  m_ipc;
  bit           m_infl;
  logic [31:0]  pops[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_req    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a bijection of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pop_at(input int k);
    return (pops.size() > k) ? pops[k] : 32'hDEAD_DEAD;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fpc  = RESET_PC;
    m_ipc  = '0;
    m_infl = 1'b0;
  endtask

  // Asserts reset, checks outputs before any clock edge, releases after one edge.
  task automatic do_reset();
    fq.branch_true = 1'b0;
    fq.id_ready    = 1'b0;
    rst = 1'b1;
    #2;
    check_eq("rst_im_req",   32'(fq.im_req),   32'h0);
    check_eq("rst_im_addr",  fq.im_addr,       RESET_PC);
    check_eq("rst_id_valid", 32'(fq.id_valid), 32'h0);
    check_eq("rst_id_inst",  fq.id_inst,       32'h0);
    check_eq("rst_id_pc",    fq.id_pc,         32'h0);
    check_eq("rst_count",    32'(fq.fq_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, compare against the queue model at negedge, advance model.
  task automatic do_cycle(input bit br, input logic [31:0] na, input bit rdy);
    bit           exp_req;
    int           sz;
    fetch_entry_t e;
    fq.branch_true = br;
    fq.new_addr    = na;
    fq.id_ready    = rdy;
    fq.im_rdata    = m_infl ? mem_word(m_ipc) : $urandom();
    @(negedge clk);
    sz      = m_q.size();
    exp_req = (sz + int'(m_infl)) < int'(DEPTH);
    check_eq("im_req",   32'(fq.im_req),   32'(exp_req));
    check_eq("im_addr",  fq.im_addr,       m_fpc);
    check_eq("id_valid", 32'(fq.id_valid), 32'(sz != 0));
    check_eq("fq_count", 32'(fq.fq_count), 32'(sz));
    if (sz != 0) begin
      check_eq("id_pc",   fq.id_pc,   m_q[0].pc);
      check_eq("id_inst", fq.id_inst, m_q[0].inst);
    end
    if (fq.im_req) n_req++;
    if (fq.id_valid && rdy && !br) pops.push_back(fq.id_pc);
    if (br) begin
      m_q.delete();
      m_infl = 1'b0;
      m_fpc  = na & 32'hFFFF_FFFC;
    end else begin
      if (sz != 0 && rdy) void'(m_q.pop_front());
      if (m_infl) begin
        e.pc   = m_ipc;
        e.inst = mem_word(m_ipc);
        m_q.push_back(e);
      end
      m_infl = exp_req;
      if (exp_req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    fq.branch_true = 1'b0;
    fq.new_addr    = '0;
    fq.id_ready    = 1'b0;
    fq.im_rdata    = '0;
    model_reset();
    do_reset();

    // Cold start: first instruction at decode in cycle 2, then one per cycle.
    pops.delete();
    repeat (8) do_cycle(1'b0, '0, 1'b1);
    check_eq("cold_npops", 32'(pops.size()), 32'd6);
    check_eq("cold_pop0", pop_at(0), 32'h0);
    check_eq("cold_pop1", pop_at(1), 32'h4);
    check_eq("cold_pop2", pop_at(2), 32'h8);

    // Stall: exactly DEPTH requests, queue saturates, then drains in order.
    do_reset();
    n_req = 0;
    repeat (8) do_cycle(1'b0, '0, 1'b0);
    check_eq("stall_nreq",  32'(n_req),        32'd4);
    check_eq("stall_count", 32'(fq.fq_count),  32'd4);
    check_eq("stall_addr",  fq.im_addr,        32'h10);
    pops.delete();
    repeat (6) do_cycle(1'b0, '0, 1'b1);
    check_eq("drain_pop0", pop_at(0), 32'h0);
    check_eq("drain_pop1", pop_at(1), 32'h4);
    check_eq("drain_pop2", pop_at(2), 32'h8);
    check_eq("drain_pop3", pop_at(3), 32'hC);
    check_eq("drain_pop4", pop_at(4), 32'h10);

    // Redirect from a full queue.
    do_reset();
    repeat (8) do_cycle(1'b0, '0, 1'b0);
    do_cycle(1'b1, 32'h40, 1'b1);
    check_eq("full_redir_valid", 32'(fq.id_valid), 32'h0);
    check_eq("full_redir_count", 32'(fq.fq_count), 32'h0);
    pops.delete();
    repeat (6) do_cycle(1'b0, '0, 1'b1);
    check_eq("full_redir_pop0", pop_at(0), 32'h40);
    check_eq("full_redir_pop1", pop_at(1), 32'h44);

    // Redirect with a response in flight and a pop in the same cycle.
    do_reset();
    repeat (5) do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b1, 32'h200, 1'b1);
    check_eq("resp_redir_count", 32'(fq.fq_count), 32'h0);
    check_eq("resp_redir_addr",  fq.im_addr,       32'h200);
    check_eq("resp_redir_req",   32'(fq.im_req),   32'h1);
    pops.delete();
    repeat (4) do_cycle(1'b0, '0, 1'b1);
    check_eq("resp_redir_pop0", pop_at(0), 32'h200);

    // Back-to-back redirects: the last one wins.
    do_cycle(1'b1, 32'h80, 1'b1);
    do_cycle(1'b1, 32'h100, 1'b1);
    pops.delete();
    repeat (5) do_cycle(1'b0, '0, 1'b1);
    check_eq("b2b_pop0", pop_at(0), 32'h100);

    // Unaligned target near the top of memory: low bits dropped, PC wraps.
    do_cycle(1'b1, 32'hFFFF_FFF9, 1'b1);
    pops.delete();
    repeat (6) do_cycle(1'b0, '0, 1'b1);
    check_eq("wrap_pop0", pop_at(0), 32'hFFFF_FFF8);
    check_eq("wrap_pop1", pop_at(1), 32'hFFFF_FFFC);
    check_eq("wrap_pop2", pop_at(2), 32'h0);

    // Asynchronous reset with three entries held.
    do_reset();
    repeat (4) do_cycle(1'b0, '0, 1'b0);
    check_eq("pre_rst_count", 32'(fq.fq_count), 32'd3);
    do_reset();
    pops.delete();
    repeat (4) do_cycle(1'b0, '0, 1'b1);
    check_eq("post_rst_pop0", pop_at(0), RESET_PC);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      bit          br;
      logic [31:0] na;
      br = ($urandom_range(0, 15) == 0);
      na = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom();
      do_cycle(br, na, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register. It drives sequential fetch addresses into `IM`, captures the returned instruction words with their PCs, and buffers them in a small FIFO. It presents one instruction per cycle to decode under a valid/ready handshake. On a taken branch from the ALU (`branch_true`/`new_addr`) it flushes all buffered and in-flight fetches and restarts at the target.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0: first fetch address after reset.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `im_req` out 1: fetch request to `IM` this cycle.
- `im_addr` out 32: byte address of the request, word aligned.
- `im_rdata` in 32: instruction word, valid exactly one cycle after `im_req`.
- `branch_true` in 1: redirect, taken branch resolved in EXE.
- `new_addr` in 32: redirect target, sampled when `branch_true`=1.
- `id_valid` out 1: head entry valid.
- `id_inst` out 32: head instruction.
- `id_pc` out 32: head PC.
- `id_ready` in 1: decode accepts head; pop when `id_valid && id_ready`.
- `fq_count` out $clog2(DEPTH+1): occupied entries, debug only.

## Operation
- Fetch PC register `fpc` resets to `RESET_PC`.
- `im_addr` = `fpc` at all times.
- `im_req`=1 when not in reset and `count + inflight < DEPTH`; on each request `fpc` += 4 (32-bit wrap, 32'hFFFF_FFFC → 0).
- `inflight` register is set to `im_req` every cycle. When `inflight`=1, `{fpc_of_request, im_rdata}` is pushed.
- Credit rule guarantees no push into a full queue; overflow is impossible by construction and is flagged by an assertion.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- Pop on empty is ignored; `id_valid`=0 whenever `count`=0 (no bypass build).
- Redirect (`branch_true`=1 in cycle t), at the edge ending t:
  - count ← 0 and pointers ← 0;
  - `inflight` ← 0, so the response arriving in t+1 is discarded;
  - `fpc` ← `new_addr`.
- Redirect overrides any push or pop in the same cycle.
- `new_addr[1:0]` are forced to 0.
- Back-to-back redirects: the last one wins.
- Ordering is strict FIFO; `id_pc` of consecutive pops differs by 4 unless a redirect intervenes.

## Timing
- Reset values: `im_req`=0, `im_addr`=`RESET_PC`, `id_valid`=0, `id_inst`=0, `id_pc`=0, `fq_count`=0.
- Reset asserted mid-operation clears everything immediately (async), including `inflight`.
- First request is in the first cycle after `rst` deasserts (cycle 0). Response arrives in cycle 1, is pushed at the end of cycle 1, and `id_valid`=1 in cycle 2.
- Steady state with `id_ready`=1: one instruction per cycle.
- Redirect latency: redirect in t, request to the target in t+1, target instruction at decode in t+3 (t+2 with bypass).
- `id_*` are driven from registered queue state only, with no combinational path from `id_ready` to `id_valid`. The bypass build is the exception (see Configuration).

## Configuration
- `FETCHQ_BYPASS_EN` defined: when `count`=0 and `inflight`=1 with no redirect, the response drives `id_*` combinationally in the same cycle. It is pushed only if not popped.
  - Cold-start latency becomes 1 cycle; redirect-to-decode becomes t+2.
- Not defined: all instructions pass through queue storage, with the latencies given above.

## Structure
- Shared package `fetch_pkg`:
  - `typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t;`
  - `localparam INST_BYTES = 4;`
  - `localparam FQ_DEFAULT_DEPTH = 4;`
- Sub-module `fetch_fifo` holds the entry array, pointers, count, push/pop/clear, and full/empty.
- `fetch_queue` holds `fpc`, `inflight`, credit logic, redirect and optional bypass.

## Test plan
- Cold start, `RESET_PC`=0, `id_ready`=1 → requests 0,4,8,…; `id_pc`=0 in cycle 2 (cycle 1 with bypass), then 4, 8 every cycle.
- `id_ready`=0 held → exactly 4 requests total, `fq_count` saturates at 4, `im_req`=0 afterwards. Release → pops 0,4,8,C in order, then fetch resumes at 0x10.
- Full queue, `branch_true`=1 with `new_addr`=0x40 → `id_valid`=0 next cycle, `fq_count`=0, and the old in-flight word is never seen. Next `id_pc`=0x40, followed by 0x44.
- Redirect coinciding with a response and a pop → the response is dropped, `fq_count`=0 after the edge, and the next request is to the target.
- Redirects to 0x80 then 0x100 on consecutive cycles → no 0x80-path instruction ever reaches decode; first `id_pc`=0x100.
- `rst` pulsed while the queue holds 3 entries → all outputs return to reset values asynchronously; after release, fetch restarts at `RESET_PC`.
